// File: rtl/fabric_obi_initiator.sv
// fabric_obi_initiator
//   Bridges a simple valid/ready command/response pair onto an OBI manager
//   port. One transaction in flight at a time: IDLE -> ADDR (request until
//   grant) -> DATA (wait for rvalid) -> RESP (hold response until accepted).
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   cmd_*                    command channel (valid/ready), 24b addr, 32b data
//   rsp_*                    response channel (valid/ready), rdata/we/err
//   obi_req_o .. obi_wdata_o OBI address phase toward the fabric
//   obi_gnt_i, obi_rvalid_i, obi_rdata_i  OBI grant and response phase
//
// Build option
//   FABRIC_OBI_TIMEOUT_EN  when defined, DATA gives up after TIMEOUT_CYCLES
//                          cycles without rvalid, answers with rsp_err_o=1 and
//                          swallows the late rvalid that eventually shows up.
//                          When undefined, DATA waits forever and rsp_err_o=0.
module fabric_obi_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_be_i,
  input  logic [23:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_we_o,
  output logic        rsp_err_o,
  output logic        obi_req_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [23:0] obi_addr_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_gnt_i,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [23:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  state_e      state_q, state_d;
  cmd_t        cmd_q;
  logic [31:0] rdata_q;
  logic        rsp_we_q;
  logic        rvalid_ok;  // rvalid that belongs to the current transaction
  logic        timeout;    // DATA gives up this cycle

`ifdef FABRIC_OBI_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_q;
  logic        drop_q;     // a timed-out rvalid is still owed by the fabric
  logic        err_q;

  // While drop_q is set the next rvalid is the stale one; it never counts.
  assign rvalid_ok = obi_rvalid_i && !drop_q;
  // rvalid wins a tie with the timeout because rvalid_ok gates it off.
  assign timeout   = (state_q == DATA) && !rvalid_ok && (tmo_cnt_q == TmoLast);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
      drop_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == DATA && !rvalid_ok && !timeout) tmo_cnt_q <= tmo_cnt_q + 16'd1;
      else                                           tmo_cnt_q <= '0;

      // A fresh timeout re-arms the flag even if a stale rvalid lands now.
      if (timeout)                     drop_q <= 1'b1;
      else if (drop_q && obi_rvalid_i) drop_q <= 1'b0;

      if (timeout)                                 err_q <= 1'b1;
      else if (state_q == DATA && rvalid_ok)       err_q <= 1'b0;
      else if (state_q == RESP && rsp_ready_i)     err_q <= 1'b0;
    end
  end

  assign rsp_err_o = err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^16'(TIMEOUT_CYCLES);

  assign rvalid_ok = obi_rvalid_i;
  assign timeout   = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state; rvalid outside DATA is a protocol violation and is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid_i)          state_d = ADDR;
      ADDR:    if (obi_gnt_i)            state_d = DATA;
      DATA:    if (rvalid_ok || timeout) state_d = RESP;
      RESP:    if (rsp_ready_i)          state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Command capture and response data. Response fields are cleared when the
  // response is accepted so rsp_rdata_o reads 0 while idle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cmd_q    <= '0;
      rdata_q  <= '0;
      rsp_we_q <= 1'b0;
    end else begin
      if (state_q == IDLE && cmd_valid_i)
        cmd_q <= '{we: cmd_we_i, be: cmd_be_i, addr: cmd_addr_i, wdata: cmd_wdata_i};

      if (state_q == DATA && rvalid_ok) begin
        rdata_q  <= obi_rdata_i;
        rsp_we_q <= cmd_q.we;
      end else if (timeout) begin
        rdata_q  <= '0;
        rsp_we_q <= cmd_q.we;
      end else if (state_q == RESP && rsp_ready_i) begin
        rdata_q  <= '0;
        rsp_we_q <= 1'b0;
      end
    end
  end

  // All outputs come from registers: the request starts the cycle after the
  // command handshake and the address phase holds still until grant.
  assign cmd_ready_o = (state_q == IDLE);
  assign obi_req_o   = (state_q == ADDR);
  assign rsp_valid_o = (state_q == RESP);
  assign obi_we_o    = cmd_q.we;
  assign obi_be_o    = cmd_q.be;
  assign obi_addr_o  = cmd_q.addr;
  assign obi_wdata_o = cmd_q.wdata;
  assign rsp_rdata_o = rdata_q;
  assign rsp_we_o    = rsp_we_q;

endmodule

// File: tb/tb_fabric_obi_initiator.sv
// Directed bench for fabric_obi_initiator. Stimulus drives the command and
// plays the fabric; expected responses go into a queue that a negedge monitor
// pops whenever a response handshake occurs.
module tb_fabric_obi_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_be;
  logic [23:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_we, rsp_err;
  logic [31:0] rsp_rdata;
  logic        obi_req, obi_we, obi_gnt, obi_rvalid;
  logic [3:0]  obi_be;
  logic [23:0] obi_addr;
  logic [31:0] obi_wdata, obi_rdata;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        we;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fabric_obi_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_be_i(cmd_be), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_we_o(rsp_we), .rsp_err_o(rsp_err),
    .obi_req_o(obi_req), .obi_we_o(obi_we), .obi_be_o(obi_be),
    .obi_addr_o(obi_addr), .obi_wdata_o(obi_wdata),
    .obi_gnt_i(obi_gnt), .obi_rvalid_i(obi_rvalid), .obi_rdata_i(obi_rdata)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted response must match the oldest expectation.
  exp_t m;
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_rsp: got rdata %h with nothing expected at %0t", rsp_rdata, $time);
      end else begin
        m = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, m.rdata);
        chk("rsp_we", 32'(rsp_we), 32'(m.we));
        chk("rsp_err", 32'(rsp_err), 32'(m.err));
      end
    end
  end

  // One transaction. gstall: cycles of gnt low; rdly: cycles before rvalid;
  // rstall: cycles of rsp_ready low; tmo: fabric never answers; late: a
  // stale rvalid arrives first in DATA and must be dropped.
  task automatic txn(input logic we, input logic [3:0] be, input logic [23:0] addr,
                     input logic [31:0] wd, input int gstall, input int rdly,
                     input logic [31:0] rd, input int rstall, input bit tmo, input bit late);
    exp_t e;
    int   n;
    e.rdata = tmo ? 32'h0 : rd;
    e.we    = we;
    e.err   = tmo;
    exp_q.push_back(e);
    cmd_valid = 1'b1; cmd_we = we; cmd_be = be; cmd_addr = addr; cmd_wdata = wd;
    rsp_ready = (rstall == 0);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    chk("req_not_early", 32'(obi_req), 32'd0);
    tick;
    // scramble the command bus: the address phase must come from registers
    cmd_valid = 1'b0; cmd_we = ~we; cmd_be = ~be; cmd_addr = ~addr; cmd_wdata = ~wd;
    for (int i = 0; i <= gstall; i++) begin
      chk("obi_req", 32'(obi_req), 32'd1);
      chk("obi_we", 32'(obi_we), 32'(we));
      chk("obi_be", 32'(obi_be), 32'(be));
      chk("obi_addr", 32'(obi_addr), 32'(addr));
      chk("obi_wdata", obi_wdata, wd);
      chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      obi_gnt = (i == gstall);
      tick;
    end
    obi_gnt = 1'b0;
    chk("req_drop", 32'(obi_req), 32'd0);
    chk("rsp_valid_early", 32'(rsp_valid), 32'd0);
    if (late) begin
      obi_rvalid = 1'b1; obi_rdata = 32'hBAD0_BAD0;
      tick;
      obi_rvalid = 1'b0;
      chk("late_dropped", 32'(rsp_valid), 32'd0);
      tick;
    end
    if (tmo) begin
      n = 0;
      while (!rsp_valid && n < 100) begin
        tick;
        n++;
      end
      chk("tmo_cycles", 32'(n), 32'd4);
    end else begin
      repeat (rdly) tick;
      obi_rvalid = 1'b1; obi_rdata = rd;
      tick;
      obi_rvalid = 1'b0; obi_rdata = 32'h0;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < rstall; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, e.rdata);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("back_idle", 32'(cmd_ready), 32'd1);
    chk("rsp_cleared", 32'(rsp_valid), 32'd0);
    chk("idle_rdata", rsp_rdata, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_be = 4'h0; cmd_addr = 24'h0;
    cmd_wdata = 32'h0; rsp_ready = 1'b0; obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_rdata = 32'h0;
    repeat (3) tick;
    rst_n = 1'b1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_obi_req", 32'(obi_req), 32'd0);
    chk("rst_obi_addr", 32'(obi_addr), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);

    // minimum-latency read
    txn(1'b0, 4'hF, 24'h000010, 32'h0, 0, 0, 32'hCAFE_0001, 0, 1'b0, 1'b0);
    // write with 3-cycle grant stall
    txn(1'b1, 4'b0101, 24'h00A5C4, 32'h1234_5678, 3, 1, 32'h0000_FFFF, 0, 1'b0, 1'b0);
    // response backpressure
    txn(1'b0, 4'h3, 24'hFFFFFC, 32'h0, 0, 2, 32'h5A5A_A5A5, 5, 1'b0, 1'b0);

`ifdef FABRIC_OBI_TIMEOUT_EN
    txn(1'b0, 4'hF, 24'h000100, 32'h0, 0, 0, 32'h0, 0, 1'b1, 1'b0);
    txn(1'b0, 4'hF, 24'h000104, 32'h0, 1, 0, 32'h0000_00AA, 0, 1'b0, 1'b1);
`endif

    // reset in the middle of DATA abandons the transaction
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_be = 4'hC; cmd_addr = 24'h123456; cmd_wdata = 32'hDEAD_BEEF;
    rsp_ready = 1'b1;
    tick;
    cmd_valid = 1'b0;
    obi_gnt = 1'b1;
    tick;
    obi_gnt = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_obi_req", 32'(obi_req), 32'd0);
    chk("mid_obi_we", 32'(obi_we), 32'd0);
    chk("mid_obi_be", 32'(obi_be), 32'd0);
    chk("mid_obi_addr", 32'(obi_addr), 32'd0);
    chk("mid_obi_wdata", obi_wdata, 32'd0);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rsp_we", 32'(rsp_we), 32'd0);
    obi_rvalid = 1'b1; obi_rdata = 32'h0BAD_F00D;
    tick;
    obi_rvalid = 1'b0;
    tick;
    chk("spurious_rvalid", 32'(rsp_valid), 32'd0);
    txn(1'b0, 4'hF, 24'h000020, 32'h0, 0, 0, 32'h7777_0002, 0, 1'b0, 1'b0);

    repeat (2) tick;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/fabric_obi_initiator.md
FABRIC_OBI_INITIATOR -- requirements
Module: fabric_obi_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning max cycles waiting for obi_rvalid_i after grant (legal range 2..65535).
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports cmd_valid_i in 1, cmd_ready_o out 1, cmd_we_i in 1, cmd_be_i in 4, cmd_addr_i in 24, cmd_wdata_i in 32  command channel, valid/ready.
REQ-005 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1, rsp_rdata_o out 32, rsp_we_o out 1, rsp_err_o out 1  response channel, valid/ready.
REQ-006 SHALL have ports obi_req_o out 1, obi_we_o out 1, obi_be_o out 4, obi_addr_o out 24, obi_wdata_o out 32  OBI manager address phase, driving the fabric's subordinate OBI port.
REQ-007 SHALL have ports obi_gnt_i in 1, obi_rvalid_i in 1, obi_rdata_i in 32  OBI response from the fabric.

Function
REQ-008 SHALL implement FSM states IDLE, ADDR, DATA, RESP; at most one transaction outstanding.
REQ-009 cmd_ready_o SHALL be 1 only in IDLE; a handshake on cmd_valid_i&&cmd_ready_o SHALL register we/be/addr/wdata and move to ADDR.
REQ-010 In ADDR, obi_req_o SHALL be 1 and obi_we/be/addr/wdata SHALL equal the registered command, stable until grant.
REQ-011 obi_req_o SHALL be asserted no earlier than the cycle after the command handshake, i.e. registered and not combinationally driven from cmd_* signals.
REQ-012 obi_gnt_i sampled high in ADDR SHALL move to DATA; obi_req_o SHALL be 0 from the next cycle.
REQ-013 ADDR SHALL have no timeout; obi_req_o SHALL stay asserted until grant.
REQ-014 obi_rvalid_i sampled in ADDR or IDLE SHALL be ignored (protocol violation), except as in REQ-022.
REQ-015 obi_rvalid_i sampled high in DATA SHALL capture obi_rdata_i into rsp_rdata_o, set rsp_err_o=0 and move to RESP.
REQ-016 For writes, obi_rdata_i SHALL still be captured, and rsp_we_o SHALL equal the command's we in RESP.
REQ-017 In RESP, rsp_valid_o SHALL be 1 with rsp_* stable; rsp_ready_i high SHALL return to IDLE.
REQ-018 rsp_rdata_o SHALL remain 0 in IDLE, and rsp_* SHALL be meaningful only while rsp_valid_o=1.
REQ-019 Minimum transaction time SHALL be: handshake cycle N, obi_req_o at N+1, grant at N+1, rvalid at N+2, rsp_valid_o at N+3, and IDLE again at N+4 if rsp_ready_i=1.

Reset
REQ-020 On rst_ni=0 at a clock edge, the block SHALL go to IDLE and set obi_req_o=0, obi_we_o=0, obi_be_o=0, obi_addr_o=0, obi_wdata_o=0, cmd_ready_o=1 (the cycle after reset release), rsp_valid_o=0, rsp_rdata_o=0, rsp_we_o=0, rsp_err_o=0, and clear the timeout counter and drop flag.
REQ-021 Reset asserted mid-transaction (any state) SHALL abandon the transaction without issuing a response; a late obi_rvalid_i after reset SHALL be ignored per REQ-014.

Configuration
REQ-022 Macro FABRIC_OBI_TIMEOUT_EN defined: in DATA, a counter SHALL increment each cycle without rvalid. On reaching TIMEOUT_CYCLES, the block SHALL move to RESP with rsp_err_o=1 and rsp_rdata_o=0, and set a drop flag. The first obi_rvalid_i sampled while the flag is set SHALL be discarded in any state and SHALL clear the flag. If rvalid and timeout coincide, rvalid SHALL win (normal response).
REQ-023 Macro FABRIC_OBI_TIMEOUT_EN undefined: no counter or drop flag; DATA SHALL wait indefinitely; rsp_err_o SHALL be constant 0. The port list SHALL be identical in both builds.

Verification
REQ-024 Read: cmd addr=24'h000010, we=0, gnt immediate, rvalid next cycle with rdata=32'hCAFE_0001 -> rsp_valid_o at handshake+3, rsp_rdata_o=32'hCAFE_0001, rsp_we_o=0, rsp_err_o=0.
REQ-025 Write with 3-cycle grant stall: be=4'b0101, wdata=32'h1234_5678, gnt low 3 cycles -> obi_req_o held for 4 cycles with stable address phase; single rsp with rsp_we_o=1.
REQ-026 Response backpressure: rsp_ready_i low 5 cycles -> rsp_valid_o and data stable; cmd_ready_o=0 throughout; IDLE one cycle after rsp_ready_i rises.
REQ-027 Timeout (macro on, TIMEOUT_CYCLES=4): no rvalid -> rsp_err_o=1, rsp_rdata_o=0; a late rvalid (rdata=32'hBAD0_BAD0) during the next transaction's DATA is dropped, and that transaction's own rvalid (32'h0000_00AA) is returned.
REQ-028 Reset mid-DATA: rst_ni low 1 cycle -> all outputs at reset values; a subsequent spurious rvalid produces no rsp_valid_o; the next command completes normally.
